// File: rtl/craft_tk_sequencer.sv
// Streams CRAFT round tweakeys from a captured key/tweak, one per valid/ready transfer.
// Latency: first tweakey one cycle after start; backpressure holds tk/tk_round/tk_last stable.
module craft_tk_sequencer #(
    parameter int ROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         decrypt,
    input  logic [127:0] key,
    input  logic [63:0]  tweak,
    output logic         busy,
    output logic         tk_valid,
    input  logic         tk_ready,
    output logic [63:0]  tk,
    output logic [7:0]   tk_round,
    output logic         tk_last,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    localparam logic [7:0]  LAST_IDX = 8'(ROUNDS - 1);
    // Nibble i of this constant is the source nibble index for output nibble i.
    localparam logic [63:0] PERM     = 64'hCAF5E892B374601D;

    state_t      state_q, state_d;
    logic [63:0] k0_q, k0_d, k1_q, k1_d, t_q, t_d, qt_q, qt_d;
    logic        dec_q, dec_d;
    logic [7:0]  r_q, r_d;
    logic        is_last;

    function automatic logic [63:0] q_perm(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            y[63-4*i -: 4] = x[63-4*int'(PERM[63-4*i -: 4]) -: 4];
        end
        return y;
    endfunction

    assign is_last = dec_q ? (r_q == 8'd0) : (r_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        k0_d    = k0_q;
        k1_d    = k1_q;
        t_d     = t_q;
        qt_d    = qt_q;
        dec_d   = dec_q;
        r_d     = r_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    k0_d    = key[127:64];
                    k1_d    = key[63:0];
                    t_d     = tweak;
                    qt_d    = q_perm(tweak);
                    dec_d   = decrypt;
                    r_d     = decrypt ? LAST_IDX : 8'd0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (tk_ready) begin
                    if (is_last) begin
                        state_d = DONE;
                    end else begin
                        r_d = dec_q ? (r_q - 8'd1) : (r_q + 8'd1);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k0_q    <= '0;
            k1_q    <= '0;
            t_q     <= '0;
            qt_q    <= '0;
            dec_q   <= 1'b0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            k0_q    <= k0_d;
            k1_q    <= k1_d;
            t_q     <= t_d;
            qt_q    <= qt_d;
            dec_q   <= dec_d;
            r_q     <= r_d;
        end
    end

    // Outputs decode only registered state and are forced to zero outside STREAM.
    always_comb begin
        busy     = (state_q != IDLE);
        tk_valid = (state_q == STREAM);
        done     = (state_q == DONE);
        tk       = '0;
        tk_round = '0;
        tk_last  = 1'b0;
        if (state_q == STREAM) begin
            tk       = (r_q[0] ? k1_q : k0_q) ^ (r_q[1] ? qt_q : t_q);
            tk_round = r_q;
            tk_last  = is_last;
        end
    end

endmodule
